// File: rtl/queue_arb_ctrl_2x111.sv
// queue_arb_ctrl_2x111
// Two-entry queue controller with a 2-way round-robin enqueue arbiter.
// The payload storage lives in an external RAM (combinational read R0,
// clocked write W0). This block owns the pointers, the occupancy tracking
// and a per-entry source tag.
// Optional build macro: QUEUE_ARB_CTRL_FLOW_EN. When it is defined, an empty
// queue passes the winning request straight through to the dequeue port.
module queue_arb_ctrl_2x111 #(
    parameter int DATA_W = 111,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq0_valid,
    output logic              enq0_ready,
    input  logic [DATA_W-1:0] enq0_bits,
    input  logic              enq1_valid,
    output logic              enq1_ready,
    input  logic [DATA_W-1:0] enq1_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    output logic              deq_src,
    output logic [1:0]        count,
    output logic              ram_R0_addr,
    output logic              ram_R0_en,
    input  logic [DATA_W-1:0] ram_R0_data,
    output logic              ram_W0_addr,
    output logic              ram_W0_en,
    output logic [DATA_W-1:0] ram_W0_data
);

    // The pointers are one bit wide, so only a depth of two is meaningful.
    if (DEPTH != 2) begin : g_depth_check
        $error("queue_arb_ctrl_2x111: DEPTH must be 2");
    end

    logic              enq_ptr;
    logic              deq_ptr;
    logic              maybe_full;
    logic              rr_last;
    logic [1:0]        tag;

    logic              ptr_match;
    logic              empty;
    logic              full;
    logic              prio;
    logic              prio_valid;
    logic              other_valid;
    logic              grant;
    logic              win_valid;
    logic [DATA_W-1:0] win_bits;
    logic              do_enq;
    logic              do_deq;
    logic              flow_thru;
    logic              ram_wr;

    // Status decode, round-robin arbitration and fire conditions.
    always_comb begin
        ptr_match   = (enq_ptr == deq_ptr);
        empty       = ptr_match & ~maybe_full;
        full        = ptr_match & maybe_full;

        prio        = ~rr_last;
        prio_valid  = prio ? enq1_valid : enq0_valid;
        other_valid = prio ? enq0_valid : enq1_valid;
        grant       = prio_valid ? prio : (other_valid ? ~prio : prio);

        win_valid   = grant ? enq1_valid : enq0_valid;
        win_bits    = grant ? enq1_bits  : enq0_bits;

        do_enq      = ~full & win_valid;
        do_deq      = deq_ready & ~empty;
`ifdef QUEUE_ARB_CTRL_FLOW_EN
        flow_thru   = empty & do_enq & deq_ready;
`else
        flow_thru   = 1'b0;
`endif
        // A flow-through transfer never touches the storage.
        ram_wr      = do_enq & ~flow_thru;
    end

    // Pointer, occupancy, arbiter history and source-tag updates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            enq_ptr    <= 1'b0;
            deq_ptr    <= 1'b0;
            maybe_full <= 1'b0;
            rr_last    <= 1'b1;
            tag        <= 2'b00;
        end else begin
            if (do_enq) begin
                rr_last <= grant;
            end
            if (ram_wr) begin
                tag[enq_ptr] <= grant;
                enq_ptr      <= ~enq_ptr;
            end
            if (do_deq) begin
                deq_ptr <= ~deq_ptr;
            end
            if (ram_wr != do_deq) begin
                maybe_full <= ram_wr;
            end
        end
    end

    // Output drive; status outputs and the RAM strobes are held off in reset.
    always_comb begin
        enq0_ready  = ~full & ~grant;
        enq1_ready  = ~full & grant;

`ifdef QUEUE_ARB_CTRL_FLOW_EN
        deq_valid   = reset & (~empty | win_valid);
        deq_bits    = empty ? win_bits : ram_R0_data;
        deq_src     = empty ? grant : tag[deq_ptr];
`else
        deq_valid   = reset & ~empty;
        deq_bits    = ram_R0_data;
        deq_src     = tag[deq_ptr];
`endif

        if (!reset) begin
            count = 2'd0;
        end else if (full) begin
            count = 2'd2;
        end else begin
            count = {1'b0, enq_ptr ^ deq_ptr};
        end

        ram_R0_addr = deq_ptr;
        ram_R0_en   = reset & ~empty;
        ram_W0_addr = enq_ptr;
        ram_W0_en   = reset & ram_wr;
        ram_W0_data = win_bits;
    end

endmodule

// File: tb/tb_queue_arb_ctrl_2x111.sv
// Testbench for queue_arb_ctrl_2x111: directed plan sequences followed by
// randomized traffic, checked through a scoreboard of expected dequeues.
module tb_queue_arb_ctrl_2x111;

    localparam int DATA_W = 111;
`ifdef QUEUE_ARB_CTRL_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    typedef struct packed {
        logic              src;
        logic [DATA_W-1:0] bits;
    } item_t;

    logic              clock;
    logic              reset;
    logic              enq0_valid, enq1_valid;
    logic              enq0_ready, enq1_ready;
    logic [DATA_W-1:0] enq0_bits, enq1_bits;
    logic              deq_valid, deq_ready, deq_src;
    logic [DATA_W-1:0] deq_bits;
    logic [1:0]        count;
    logic              ram_R0_addr, ram_R0_en, ram_W0_addr, ram_W0_en;
    logic [DATA_W-1:0] ram_R0_data, ram_W0_data;

    logic [DATA_W-1:0] mem [2];

    item_t exp_q[$];
    bit    model_rr;
    int    n_cmp = 0;
    int    n_bad = 0;

    queue_arb_ctrl_2x111 #(.DATA_W(DATA_W), .DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .enq0_valid(enq0_valid), .enq0_ready(enq0_ready), .enq0_bits(enq0_bits),
        .enq1_valid(enq1_valid), .enq1_ready(enq1_ready), .enq1_bits(enq1_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .deq_src(deq_src), .count(count),
        .ram_R0_addr(ram_R0_addr), .ram_R0_en(ram_R0_en), .ram_R0_data(ram_R0_data),
        .ram_W0_addr(ram_W0_addr), .ram_W0_en(ram_W0_en), .ram_W0_data(ram_W0_data)
    );

    // External storage RAM: clocked write, combinational read.
    always @(posedge clock) begin
        if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
    end
    assign ram_R0_data = mem[ram_R0_addr];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the reference model predicts the handshake.
    task automatic step(input logic v0, input logic [DATA_W-1:0] b0,
                        input logic v1, input logic [DATA_W-1:0] b1,
                        input logic dr, input logic rst_n);
        bit v[2];
        bit prio, grant, accept, fullq, emptyq;
        item_t it;
        @(negedge clock);
        enq0_valid = v0; enq0_bits = b0;
        enq1_valid = v1; enq1_bits = b1;
        deq_ready  = dr; reset = rst_n;
        #1;
        if (!rst_n) begin
            chk("rst_count", 128'(count), 128'd0);
            chk("rst_deq_valid", 128'(deq_valid), 128'd0);
            chk("rst_ram_w_en", 128'(ram_W0_en), 128'd0);
            chk("rst_ram_r_en", 128'(ram_R0_en), 128'd0);
            exp_q.delete();
            model_rr = 1'b1;
        end else begin
            v[0] = v0; v[1] = v1;
            fullq  = (exp_q.size() == 2);
            emptyq = (exp_q.size() == 0);
            prio   = ~model_rr;
            if (v[prio])       grant = prio;
            else if (v[~prio]) grant = ~prio;
            else               grant = prio;
            accept = !fullq && v[grant];
            chk("count", 128'(count), 128'(exp_q.size()));
            chk("deq_valid", 128'(deq_valid), 128'(!emptyq || (FLOW && (v0 || v1))));
            chk("enq0_ready", 128'(enq0_ready), 128'(!fullq && grant == 1'b0));
            chk("enq1_ready", 128'(enq1_ready), 128'(!fullq && grant == 1'b1));
            chk("ram_w_en", 128'(ram_W0_en), 128'(accept && !(FLOW && emptyq && dr)));
            if (accept) begin
                model_rr = grant;
                it.src   = grant;
                it.bits  = grant ? b1 : b0;
                exp_q.push_back(it);
            end
        end
    endtask

    // Monitor: every dequeue handshake pops one expected entry.
    initial begin
        item_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset && deq_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL deq_unexpected: got src %0d bits %0h expected no entry", deq_src, deq_bits);
                end else begin
                    e = exp_q.pop_front();
                    chk("deq_src", 128'(deq_src), 128'(e.src));
                    chk("deq_bits", 128'(deq_bits), 128'(e.bits));
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] rnd_bits();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    initial begin
        logic [DATA_W-1:0] z;
        z = '0;
        reset = 1'b0; deq_ready = 1'b0;
        enq0_valid = 1'b0; enq1_valid = 1'b0;
        enq0_bits = '0; enq1_bits = '0;
        model_rr = 1'b1;

        step(0, z, 0, z, 0, 0);
        step(0, z, 0, z, 0, 0);
        step(0, z, 0, z, 0, 1);
        // single enqueue from requester 0, then pop
        step(1, 111'h1234, 0, z, 0, 1);
        step(0, z, 0, z, 1, 1);
        step(0, z, 0, z, 0, 1);
        // both requesters, no consumer: fill, then drain
        step(1, 111'h10, 1, 111'h11, 0, 1);
        step(1, 111'h20, 1, 111'h21, 0, 1);
        step(1, 111'h30, 1, 111'h31, 0, 1);
        step(0, z, 0, z, 1, 1);
        step(0, z, 0, z, 1, 1);
        step(0, z, 0, z, 0, 1);
        // sustained streaming with alternating grants
        for (int i = 0; i < 6; i++) step(1, 111'(100 + 2 * i), 1, 111'(101 + 2 * i), 1, 1);
        step(0, z, 0, z, 1, 1);
        step(0, z, 0, z, 1, 1);
        // full queue: dequeue only, enqueue taken next cycle
        step(1, 111'h40, 1, 111'h41, 0, 1);
        step(1, 111'h50, 1, 111'h51, 0, 1);
        step(0, z, 1, 111'h61, 1, 1);
        step(0, z, 1, 111'h71, 1, 1);
        step(0, z, 0, z, 1, 1);
        step(0, z, 0, z, 1, 1);
        // reset while full with fires pending
        step(1, 111'h80, 1, 111'h81, 0, 1);
        step(1, 111'h90, 1, 111'h91, 0, 1);
        step(1, 111'hA0, 1, 111'hA1, 1, 0);
        step(1, 111'hB0, 1, 111'hB1, 0, 1);
        step(0, z, 0, z, 1, 1);
        // empty queue with a ready consumer
        step(1, 111'hABC, 0, z, 1, 1);
        step(0, z, 0, z, 1, 1);

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), rnd_bits(),
                 1'($urandom_range(0, 1)), rnd_bits(),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) != 0));
        end
        step(0, z, 0, z, 1, 1);
        step(0, z, 0, z, 1, 1);
        step(0, z, 0, z, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/queue_arb_ctrl_2x111.md
Name: queue_arb_ctrl_2x111

Overview:
- Controller and 2-way round-robin enqueue arbiter for a 2-entry, 111-bit storage RAM.
- The RAM has one combinational-read port R0 and one clocked-write port W0. It is instantiated by the parent, clocked from `clock`, and wired to this block's `ram_*` ports.
- The block owns the enqueue/dequeue pointers, the full/empty tracking and per-entry source tags.
- It presents a single ready/valid dequeue stream to the consumer.

Parameters:
- DATA_W, 111, payload width. Must equal the RAM word width.
- DEPTH, 2, entry count. Fixed at 2; pointers are 1 bit. Any other value is a configuration error.

Ports:
- clock  in  1  block clock; also the RAM clock
- reset  in  1  synchronous, active-low reset; sampled on rising `clock`
- enq0_valid  in  1  requester 0 offers data
- enq0_ready  out  1  requester 0 accepted this cycle if valid
- enq0_bits  in  DATA_W  requester 0 payload
- enq1_valid  in  1  requester 1 offers data
- enq1_ready  out  1  requester 1 accepted this cycle if valid
- enq1_bits  in  DATA_W  requester 1 payload
- deq_valid  out  1  head entry available
- deq_ready  in  1  consumer accepts head
- deq_bits  out  DATA_W  head payload
- deq_src  out  1  requester index that wrote the head entry
- count  out  2  occupancy, 0..2
- ram_R0_addr  out  1  read address (= deq_ptr)
- ram_R0_en  out  1  read enable (= !empty)
- ram_R0_data  in  DATA_W  read data; combinational from ram_R0_addr
- ram_W0_addr  out  1  write address (= enq_ptr)
- ram_W0_en  out  1  write enable (= do_enq)
- ram_W0_data  out  DATA_W  write data (winner's bits)

Behaviour:
- State:
  - enq_ptr, deq_ptr: 1 bit each.
  - maybe_full: 1 bit.
  - rr_last: 1 bit, index of the last granted requester.
  - tag[0:1]: 1 bit each, source tag per entry.
- Status decode:
  - ptr_match = (enq_ptr == deq_ptr)
  - empty = ptr_match & !maybe_full
  - full = ptr_match & maybe_full
  - count = full ? 2 : (enq_ptr - deq_ptr) mod 2
- Arbitration (combinational):
  - prio = !rr_last.
  - grant = prio if enq[prio]_valid, else the other requester if its valid is high, else prio.
  - enqN_ready = !full & (grant == N). This depends on the other requester's valid; enqN_ready never depends on deq_ready.
- Enqueue (do_enq = !full & enq[grant]_valid), on the clock edge:
  - RAM writes ram_W0_data to ram_W0_addr.
  - tag[enq_ptr] <= grant.
  - enq_ptr toggles.
  - rr_last <= grant.
- Dequeue (do_deq = deq_ready & !empty), on the clock edge: deq_ptr toggles.
- Dequeue outputs: deq_valid = !empty; deq_bits = ram_R0_data; deq_src = tag[deq_ptr]. deq_bits and deq_src are don't-care while deq_valid = 0.
- maybe_full: updated to do_enq only when do_enq != do_deq; otherwise held.
- Latency: 1 cycle minimum from enqueue fire to deq_valid.
- Throughput: 1 transfer per cycle sustained.
- Simultaneous enqueue and dequeue:
  - When count = 1, both fire; count stays 1.
  - When full, only the dequeue fires: enqueue is blocked this cycle and accepted on the next.
  - When empty, only the enqueue fires.
- Wrap-around: pointers wrap naturally, 1 -> 0.
- Reset behaviour (reset = 0 at a clock edge):
  - enq_ptr = 0, deq_ptr = 0, maybe_full = 0, rr_last = 1, tags = 0.
  - Reset overrides any same-cycle fire. The RAM write is suppressed during reset (ram_W0_en = 0).
  - Output values in reset: deq_valid = 0, count = 0, ram_W0_en = 0, ram_R0_en = 0.
  - enq0_ready = 1 and enq1_ready = 0 when no valids are asserted.
- Reset mid-operation: all stored entries are discarded. RAM contents are left stale and are unreachable.

Optional Feature:
- Macro: QUEUE_ARB_CTRL_FLOW_EN
- Defined (flow-through when empty):
  - If empty & enq[grant]_valid: deq_valid = 1, deq_bits = winner bits, deq_src = grant.
  - If deq_ready is also high: the RAM write is suppressed (ram_W0_en = 0), pointers and maybe_full are unchanged, and rr_last <= grant. The transfer has zero latency.
- Not defined: deq_valid is driven solely by stored entries. Minimum latency is 1 cycle.

Test Plan:
- Reset, then idle:
  - deq_valid = 0, count = 0, enq0_ready = 1, enq1_ready = 0, ram_W0_en = 0.
- Only enq0 valid with bits 0x1234, held for 1 cycle, then deq_ready = 1:
  - Next cycle: deq_valid = 1, deq_bits = 0x1234, deq_src = 0.
  - After the pop: count = 0.
- Both requesters valid continuously, deq_ready = 0:
  - Grants go 0 then 1; count reaches 2; both readies = 0 while full.
  - Popping yields src 0 then src 1.
- Both requesters valid, deq_ready = 1 for 6 cycles:
  - Grants alternate 0,1,0,1,… one per cycle; count stays at 1 after the first cycle.
  - deq_src sequence matches the grants; pointers wrap at least twice.
- Full queue (count = 2) with deq_ready = 1 and enq1_valid = 1:
  - That cycle: dequeue only, enq1_ready = 0.
  - Next cycle: enq1 is accepted; count holds at 1.
- Assert reset = 0 for 1 cycle while count = 2 and fires are pending:
  - count = 0, deq_valid = 0, no RAM write that cycle.
  - First subsequent grant goes to requester 0.
  - With QUEUE_ARB_CTRL_FLOW_EN defined: empty queue, enq0 = 0xABC and deq_ready = 1 give a same-cycle deq_bits = 0xABC and ram_W0_en = 0.
